// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared idle levels and default debounce length for the input conditioner
package io_cond_pkg;

    localparam logic BTN_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    localparam int DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/io_debounce_ch.sv
// rtl/io_debounce_ch.sv - one channel: two-flop synchroniser, stability counter, edge pulses
module io_debounce_ch
    import io_cond_pkg::*;
#(
    parameter logic IDLE_VAL        = SW_IDLE,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw pin, count consecutive disagreeing cycles, accept the new level
    // once the count completes; pulses are registered so they line up with the new level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1      <= IDLE_VAL;
            s2      <= IDLE_VAL;
            o_level <= IDLE_VAL;
            cnt     <= '0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            s1     <= i_raw;
            s2     <= s1;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (s2 == o_level) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_ONE;
            end else begin
                o_level <= s2;
                cnt     <= '0;
                o_rise  <= s2;
                o_fall  <= ~s2;
            end
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - debounced buttons/switches with edge pulses; IO_BTN_TOGGLE_EN adds o_btn_toggle
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int NUM_SW          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    input  logic [NUM_SW-1:0]  i_sw_raw,
    output logic [NUM_BTN-1:0] o_io_btn,
    output logic [NUM_SW-1:0]  o_io_sw,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic [NUM_BTN-1:0] o_btn_release,
    output logic [NUM_SW-1:0]  o_sw_change
`ifdef IO_BTN_TOGGLE_EN
    ,
    output logic [NUM_BTN-1:0] o_btn_toggle
`endif
);

    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    // Buttons idle high: a falling debounced level is a press, a rising one a release.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        io_debounce_ch #(
            .IDLE_VAL        (BTN_IDLE),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_btn_raw[i]),
            .o_level (o_io_btn[i]),
            .o_rise  (o_btn_release[i]),
            .o_fall  (o_btn_press[i])
        );
    end

    // Switches idle low; either direction counts as a change.
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        io_debounce_ch #(
            .IDLE_VAL        (SW_IDLE),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_sw_raw[i]),
            .o_level (o_io_sw[i]),
            .o_rise  (sw_rise[i]),
            .o_fall  (sw_fall[i])
        );
    end

    assign o_sw_change = sw_rise | sw_fall;

`ifdef IO_BTN_TOGGLE_EN
    // Latched on/off per button: flips the cycle after each press pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_btn_toggle <= '0;
        end else begin
            o_btn_toggle <= o_btn_toggle ^ o_btn_press;
        end
    end
`endif

endmodule
